// File: rtl/jtobj_line_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : jtobj_line_scan                                               |
// | Purpose  : per-line object table scanner; selects objects crossing the   |
// |            next line and emits 16-pixel tile-column draw requests.       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module jtobj_line_scan #(
    parameter int OBJW = 8,
    parameter int MAXT = 64,
    parameter int FAW  = 2
) (
    input  logic            rst,
    input  logic            clk,
    input  logic            cen,
    input  logic            hs,
    input  logic [8:0]      vdump,
    output logic [OBJW+1:0] tbl_addr,
    input  logic [15:0]     tbl_dout,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [15:0]     req_code,
    output logic [8:0]      req_hpos,
    output logic [3:0]      req_ysub,
    output logic            req_hflip,
    output logic [7:0]      req_attr,
    output logic            busy,
    output logic            ovf,
    output logic            late
);

    localparam int c_TCW   = $clog2(MAXT + 1);
    localparam int c_DEPTH = 2 ** FAW;
    localparam int c_RQW   = 38;
    localparam logic [FAW:0] c_FULL = {1'b1, {FAW{1'b0}}};

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_RD0  = 3'd1;
    localparam logic [2:0] c_RD1  = 3'd2;
    localparam logic [2:0] c_RD2  = 3'd3;
    localparam logic [2:0] c_RD3  = 3'd4;
    localparam logic [2:0] c_CHK  = 3'd5;
    localparam logic [2:0] c_EMIT = 3'd6;
    localparam logic [2:0] c_NEXT = 3'd7;

    logic [2:0]       r_state, w_state_nx;
    logic             r_hs_d, r_ovf, r_late;
    logic [OBJW-1:0]  r_obj;
    logic [8:0]       r_vline, r_y, r_x;
    logic             r_vflip, r_hflip;
    logic [1:0]       r_vsz, r_hsz;
    logic [15:0]      r_code;
    logic [7:0]       r_attr;
    logic [2:0]       r_row, r_col;
    logic [3:0]       r_ysub;
    logic [c_TCW-1:0] r_tcnt;

    logic [c_RQW-1:0] r_fifo [c_DEPTH];
    logic [FAW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [FAW:0]     r_fcnt;

    logic w_hs_rise, w_abort, w_full, w_empty, w_pop, w_push, w_room;
    logic w_budget_hit, w_set_ovf, w_last_col, w_last_obj, w_in_zone;
    logic [1:0]       w_word;
    logic [8:0]       w_d, w_req_hpos;
    logic [7:0]       w_vzoom, w_height;
    logic [16:0]      w_prod;
    logic [10:0]      w_s;
    logic [2:0]       w_rmask, w_row_raw, w_row, w_ncol_m1, w_tc;
    logic [15:0]      w_req_code;
    logic [c_RQW-1:0] w_req;

    assign w_hs_rise    = cen && hs && !r_hs_d;
    assign w_abort      = w_hs_rise && busy;
    assign w_full       = (r_fcnt == c_FULL);
    assign w_empty      = (r_fcnt == '0);
    assign w_pop        = cen && !w_empty && req_ready && !w_abort;
    assign w_room       = !w_full || w_pop;
    assign w_budget_hit = (r_tcnt == c_TCW'(MAXT));
    assign w_last_obj   = &r_obj;

    // Vertical zone test; w3 (zoom/attr) is on tbl_dout during CHK.
    assign w_d       = r_vline - r_y;
    assign w_vzoom   = tbl_dout[15:8];
    assign w_prod    = {8'd0, w_d} * {9'd0, w_vzoom};
    assign w_s       = 11'(w_prod >> 6);
    assign w_height  = 8'd16 << r_vsz;
    assign w_in_zone = (w_vzoom != 8'd0) && !w_d[8] && (w_s < {3'd0, w_height});
    assign w_rmask   = ~(3'b111 << r_vsz);
    assign w_row_raw = w_s[6:4] & w_rmask;
    assign w_row     = r_vflip ? (w_rmask - w_row_raw) : w_row_raw;

    assign w_ncol_m1  = ~(3'b111 << r_hsz);
    assign w_tc       = r_hflip ? (w_ncol_m1 - r_col) : r_col;
    assign w_last_col = (r_col == w_ncol_m1);
    assign w_req_code = r_code + ({13'd0, r_row} << r_hsz) + {13'd0, w_tc};
    assign w_req_hpos = r_x + {2'b00, r_col, 4'b0000};
    assign w_req      = {w_req_code, w_req_hpos, r_ysub, r_hflip, r_attr};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else if (cen) begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        if (w_hs_rise) begin
            w_state_nx = c_RD0;
        end else begin
            case (r_state)
                c_IDLE: w_state_nx = c_IDLE;
                c_RD0:  w_state_nx = c_RD1;
                c_RD1:  w_state_nx = tbl_dout[15] ? c_RD2 : c_NEXT;
                c_RD2:  w_state_nx = c_RD3;
                c_RD3:  w_state_nx = c_CHK;
                c_CHK:  w_state_nx = w_in_zone ? c_EMIT : c_NEXT;
                c_EMIT: begin
                    if (w_budget_hit) begin
                        w_state_nx = c_IDLE;
                    end else if (w_room && w_last_col) begin
                        w_state_nx = c_NEXT;
                    end
                end
                c_NEXT:  w_state_nx = w_last_obj ? c_IDLE : c_RD0;
                default: w_state_nx = c_IDLE;
            endcase
        end
    end

    always_comb begin
        w_word    = 2'd0;
        w_push    = 1'b0;
        w_set_ovf = 1'b0;
        busy      = (r_state != c_IDLE);
        case (r_state)
            c_RD1: w_word = tbl_dout[15] ? 2'd1 : 2'd0;
            c_RD2: w_word = 2'd2;
            c_RD3: w_word = 2'd3;
            c_EMIT: begin
                if (cen && !w_hs_rise) begin
                    if (w_budget_hit) begin
                        w_set_ovf = 1'b1;
                    end else if (w_room) begin
                        w_push = 1'b1;
                    end
                end
            end
            default: w_word = 2'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hs_d  <= 1'b0;
            r_late  <= 1'b0;
            r_ovf   <= 1'b0;
            r_vline <= '0;
            r_obj   <= '0;
            r_tcnt  <= '0;
            r_vflip <= 1'b0;
            r_hflip <= 1'b0;
            r_vsz   <= '0;
            r_hsz   <= '0;
            r_y     <= '0;
            r_code  <= '0;
            r_x     <= '0;
            r_attr  <= '0;
            r_row   <= '0;
            r_ysub  <= '0;
            r_col   <= '0;
        end else if (cen) begin
            r_hs_d <= hs;
            r_late <= w_abort;
            if (w_hs_rise) begin
                r_vline <= vdump + 9'd1;
                r_obj   <= '0;
                r_tcnt  <= '0;
                r_ovf   <= 1'b0;
            end else begin
                case (r_state)
                    c_RD1: {r_vflip, r_hflip, r_vsz, r_hsz, r_y} <= tbl_dout[14:0];
                    c_RD2: r_code <= tbl_dout;
                    c_RD3: r_x <= tbl_dout[8:0];
                    c_CHK: begin
                        r_attr <= tbl_dout[7:0];
                        r_row  <= w_row;
                        r_ysub <= w_s[3:0] ^ {4{r_vflip}};
                        r_col  <= 3'd0;
                    end
                    c_EMIT: begin
                        if (w_push) begin
                            r_col  <= r_col + 3'd1;
                            r_tcnt <= r_tcnt + c_TCW'(1);
                        end
                    end
                    c_NEXT: r_obj <= r_obj + OBJW'(1);
                    default: r_obj <= r_obj;
                endcase
                // Budget overflow ends the line; park the object index back at 0.
                if (w_set_ovf) begin
                    r_ovf <= 1'b1;
                    r_obj <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_req;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fcnt   <= '0;
        end else if (cen) begin
            if (w_abort) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_fcnt   <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + FAW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + FAW'(1);
                if (w_push && !w_pop) begin
                    r_fcnt <= r_fcnt + {{FAW{1'b0}}, 1'b1};
                end else if (!w_push && w_pop) begin
                    r_fcnt <= r_fcnt - {{FAW{1'b0}}, 1'b1};
                end
            end
        end
    end

    always_comb begin
        req_valid = !w_empty;
        {req_code, req_hpos, req_ysub, req_hflip, req_attr} = w_empty ? '0 : r_fifo[r_rd_ptr];
    end

    assign tbl_addr = {r_obj, w_word};
    assign ovf      = r_ovf;
    assign late     = r_late;

endmodule
`default_nettype wire
